bcd_score_counter: RTL and testbench
====================================

Name: bcd_score_counter

Overview:
- Parametrised N-digit BCD up/down counter for on-screen scores and hit counts.
- Successor to the fixed two-digit, increment-only score counter.
- Adds decrement, parallel load, a wrap/saturate mode and overflow/underflow pulses.
- Sits between the game-control FSM (which issues the inc/dec/clr/load strobes) and the text/score renderer (which consumes the BCD digits).

Parameters:
- NUM_DIGITS, 2, number of BCD digits; legal range 1..8.
- WRAP, 1, 1 = roll over at the limits (all-9s up to 0, 0 down to all-9s); 0 = saturate at the limits.
- WIN_SCORE, 0, target value in binary, range 0..10^NUM_DIGITS-1; used only when WIN_DETECT_EN is defined.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- d_inc  input  1  increment strobe, sampled each clk.
- d_dec  input  1  decrement strobe, sampled each clk.
- d_clr  input  1  clear all digits to 0.
- d_load  input  1  load load_val.
- load_val  input  4*NUM_DIGITS  BCD value to load; digit 0 is bits [3:0].
- digits  output  4*NUM_DIGITS  registered BCD count; digit 0 (least significant) is bits [3:0].
- ovf  output  1  one-cycle pulse: an increment was applied at all-9s.
- unf  output  1  one-cycle pulse: a decrement was applied at 0.
- at_zero  output  1  combinational, digits == 0.
- at_max  output  1  combinational, every digit == 9.
- win  output  1  sticky target-reached flag (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. reset is sampled only on rising clk.
- Reset value of every output: digits = 0, ovf = 0, unf = 0, win = 0, at_zero = 1, at_max = 0.
- Priority per cycle: reset > d_clr > d_load > count.
- Count operation:
  - Only d_inc = 1 with d_dec = 0: increment.
  - Only d_dec = 1 with d_inc = 0: decrement.
  - Both high, or both low: hold.
- Latency: the new digits value is visible the cycle after the strobe is sampled. ovf and unf assert in that same following cycle for exactly one cycle.
- Increment: ripple-carry across digits. A digit at 9 becomes 0 and carries; the first digit below 9 is incremented; digits above it are unchanged.
- Increment at all-9s:
  - WRAP=1: digits go to 0, ovf pulses.
  - WRAP=0: digits hold all-9s, ovf pulses.
- Decrement: ripple-borrow. A digit at 0 becomes 9 and borrows; the first non-zero digit is decremented.
- Decrement at 0:
  - WRAP=1: digits go to all-9s, unf pulses.
  - WRAP=0: digits hold 0, unf pulses.
- Load: each load_val nibble greater than 9 is clamped to 9 before storing. Load never pulses ovf or unf.
- Clear and load cancel any count request in the same cycle; ovf and unf are 0 in the following cycle.
- Repeated strobes on consecutive cycles count once per cycle. There is no edge detection; the caller supplies single-cycle strobes.
- No internal state beyond the digit registers, the ovf/unf registers and the win register.

Optional Feature:
- Macro: BCD_SCORE_WIN_DETECT_EN.
- Defined:
  - win is set on the cycle after digits first equals WIN_SCORE (converted to BCD at elaboration), whether reached by increment, decrement or load.
  - win stays set until reset, d_clr or d_load.
  - While win = 1, d_inc and d_dec are ignored (digits frozen, no ovf/unf).
- Not defined:
  - win is tied to 0.
  - WIN_SCORE is ignored.
  - No counting is inhibited.

Test Plan:
- Increment chain and overflow, NUM_DIGITS=2, WRAP=1: reset, then 100 single-cycle d_inc pulses -> digits step 00..99 then 00; ovf is high for exactly one cycle after the 100th pulse.
- Saturation, WRAP=0: load 0x99, then d_inc -> digits stay 0x99 and ovf pulses once. Clear, then d_dec -> digits stay 0x00 and unf pulses once.
- Borrow chain, NUM_DIGITS=3: load 0x100, then d_dec -> digits = 0x099. Load 0x000 with WRAP=1, then d_dec -> digits = 0x999 and unf pulses.
- Priority and simultaneity:
  - d_inc and d_dec together at 0x42 -> digits hold 0x42.
  - d_clr with d_inc -> digits = 0x00, no ovf.
  - reset asserted together with d_load -> digits = 0x00.
  - load_val = 0xA7 -> digits = 0x97.
- Reset mid-count: digits = 0x57, reset held for one cycle while d_inc is high -> next cycle digits = 0x00, ovf = 0, at_zero = 1. Counting resumes on the cycle after reset deasserts.
- BCD_SCORE_WIN_DETECT_EN defined, WIN_SCORE=11:
  - 11 increments -> win = 1 one cycle after digits = 0x11.
  - Further d_inc -> digits stay 0x11.
  - d_clr -> win = 0, digits = 0x00.

Source files
------------

// File: rtl/bcd_score_counter.sv
// ---------------------------------------------------------------------------
// bcd_score_counter
//
// Parametrised N-digit BCD up/down counter for on-screen scores and hit
// counts. The game-control FSM drives the single-cycle strobes; the score
// renderer consumes the registered BCD digits.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits (1..8)
//   WRAP        1 = roll over at the limits, 0 = saturate at the limits
//   WIN_SCORE   binary target value, used only with BCD_SCORE_WIN_DETECT_EN
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   d_inc     in   increment strobe
//   d_dec     in   decrement strobe
//   d_clr     in   clear all digits to 0
//   d_load    in   load load_val (nibbles above 9 are clamped to 9)
//   load_val  in   BCD load value, digit 0 in bits [3:0]
//   digits    out  registered BCD count, digit 0 in bits [3:0]
//   ovf       out  one-cycle pulse: increment applied at all-9s
//   unf       out  one-cycle pulse: decrement applied at 0
//   at_zero   out  digits == 0 (combinational)
//   at_max    out  every digit == 9 (combinational)
//   win       out  sticky target-reached flag
//
// Optional feature macro: BCD_SCORE_WIN_DETECT_EN
//   Defined: win sets the cycle after digits first equals WIN_SCORE, stays
//   set until reset/d_clr/d_load, and freezes counting while set.
//   Undefined: win is tied to 0 and counting is never inhibited.
// ---------------------------------------------------------------------------
module bcd_score_counter #(
    parameter int          NUM_DIGITS = 2,
    parameter bit          WRAP       = 1'b1,
    parameter int unsigned WIN_SCORE  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_inc,
    input  logic                    d_dec,
    input  logic                    d_clr,
    input  logic                    d_load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    ovf,
    output logic                    unf,
    output logic                    at_zero,
    output logic                    at_max,
    output logic                    win
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    // Binary to BCD, evaluated at elaboration for the win target.
    function automatic logic [W-1:0] to_bcd(input int unsigned val);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Ripple-carry BCD increment; MSB of the result is the carry out,
    // which is set only when the input was all-9s.
    function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Ripple-borrow BCD decrement; MSB of the result is the borrow out,
    // which is set only when the input was zero.
    function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    // Clamp any non-BCD nibble (A..F) to 9.
    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    logic [W-1:0] digits_q, digits_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         win_q, win_d;

    logic [W-1:0] inc_val, dec_val;
    logic         inc_carry, dec_borrow;
    logic         inc_req, dec_req;
    logic         count_en;
    logic         win_hit;

    assign inc_req = d_inc & ~d_dec;
    assign dec_req = d_dec & ~d_inc;
    assign win_hit = (digits_q == WIN_BCD);

    always_comb begin
        digits_d = digits_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;

        {inc_carry, inc_val}  = bcd_inc(digits_q);
        {dec_borrow, dec_val} = bcd_dec(digits_q);

`ifdef BCD_SCORE_WIN_DETECT_EN
        count_en = ~win_q;
        win_d    = win_q | win_hit;
`else
        // Target detection is absent in this build; win_hit is masked off.
        count_en = 1'b1;
        win_d    = win_hit & 1'b0;
`endif

        if (d_clr) begin
            digits_d = '0;
            win_d    = 1'b0;
        end else if (d_load) begin
            digits_d = clamp_load(load_val);
            win_d    = 1'b0;
        end else if (count_en && inc_req) begin
            ovf_d    = inc_carry;
            digits_d = (inc_carry && !WRAP) ? ALL_NINES : inc_val;
        end else if (count_en && dec_req) begin
            unf_d    = dec_borrow;
            digits_d = (dec_borrow && !WRAP) ? '0 : dec_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            win_q    <= win_d;
        end
    end

    assign digits  = digits_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign win     = win_q;
    assign at_zero = (digits_q == '0);
    assign at_max  = (digits_q == ALL_NINES);

endmodule

// File: tb/tb_bcd_score_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_score_counter
//
// Directed bench for bcd_score_counter. Three instances share one stimulus
// set: A (2 digits, wrap), S (2 digits, saturate), C (3 digits, wrap).
// A fourth instance W (2 digits, wrap, WIN_SCORE=11) has its own strobes
// and exercises the win flag.
// ---------------------------------------------------------------------------
module tb_bcd_score_counter;

`ifdef BCD_SCORE_WIN_DETECT_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, inc, dec, clr, ld;
    logic [11:0] lv;

    logic [7:0]  a_dig, s_dig;
    logic [11:0] c_dig;
    logic        a_ovf, a_unf, a_zero, a_max, a_win;
    logic        s_ovf, s_unf, s_zero, s_max, s_win;
    logic        c_ovf, c_unf, c_zero, c_max, c_win;

    logic        w_inc, w_dec, w_clr, w_ld;
    logic [7:0]  w_lv, w_dig;
    logic        w_ovf, w_unf, w_zero, w_max, w_win;

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b1), .WIN_SCORE(0)) u_a (
        .clk(clk), .reset(rst), .d_inc(inc), .d_dec(dec), .d_clr(clr),
        .d_load(ld), .load_val(lv[7:0]), .digits(a_dig), .ovf(a_ovf),
        .unf(a_unf), .at_zero(a_zero), .at_max(a_max), .win(a_win));

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b0), .WIN_SCORE(0)) u_s (
        .clk(clk), .reset(rst), .d_inc(inc), .d_dec(dec), .d_clr(clr),
        .d_load(ld), .load_val(lv[7:0]), .digits(s_dig), .ovf(s_ovf),
        .unf(s_unf), .at_zero(s_zero), .at_max(s_max), .win(s_win));

    bcd_score_counter #(.NUM_DIGITS(3), .WRAP(1'b1), .WIN_SCORE(0)) u_c (
        .clk(clk), .reset(rst), .d_inc(inc), .d_dec(dec), .d_clr(clr),
        .d_load(ld), .load_val(lv), .digits(c_dig), .ovf(c_ovf),
        .unf(c_unf), .at_zero(c_zero), .at_max(c_max), .win(c_win));

    bcd_score_counter #(.NUM_DIGITS(2), .WRAP(1'b1), .WIN_SCORE(11)) u_w (
        .clk(clk), .reset(rst), .d_inc(w_inc), .d_dec(w_dec), .d_clr(w_clr),
        .d_load(w_ld), .load_val(w_lv), .digits(w_dig), .ovf(w_ovf),
        .unf(w_unf), .at_zero(w_zero), .at_max(w_max), .win(w_win));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial begin
        rst = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0; ld = 1'b0; lv = '0;
        w_inc = 1'b0; w_dec = 1'b0; w_clr = 1'b0; w_ld = 1'b0; w_lv = '0;
        #2;

        // Reset together with a load: reset wins.
        rst = 1'b1; ld = 1'b1; lv = 12'h055;
        tick();
        rst = 1'b0; ld = 1'b0;
        chk("rst_a_dig", a_dig, 8'h00);
        chk("rst_a_ovf", a_ovf, 1'b0);
        chk("rst_a_unf", a_unf, 1'b0);
        chk("rst_a_zero", a_zero, 1'b1);
        chk("rst_a_max", a_max, 1'b0);
        chk("rst_a_win", a_win, 1'b0);
        chk("rst_c_dig", c_dig, 12'h000);
        chk("rst_w_win", w_win, 1'b0);

`ifndef BCD_SCORE_WIN_DETECT_EN
        // 100 single-cycle increments, each followed by an idle cycle.
        for (int k = 1; k <= 100; k++) begin
            inc = 1'b1;
            tick();
            inc = 1'b0;
            chk("inc_a_dig", a_dig, bcd(k % 100));
            chk("inc_a_ovf", a_ovf, (k == 100));
            chk("inc_s_dig", s_dig, (k == 100) ? 12'h099 : bcd(k));
            chk("inc_s_ovf", s_ovf, (k == 100));
            chk("inc_c_dig", c_dig, bcd(k));
            tick();
            chk("idle_a_ovf", a_ovf, 1'b0);
            chk("idle_a_dig", a_dig, bcd(k % 100));
        end
        chk("wrap_a_zero", a_zero, 1'b1);
        chk("sat_s_max", s_max, 1'b1);
        chk("c_ovf_none", c_ovf, 1'b0);

        // Load 099 then increment: wrap, saturate, carry into digit 2.
        ld = 1'b1; lv = 12'h099;
        tick();
        ld = 1'b0;
        chk("ld99_a_max", a_max, 1'b1);
        chk("ld99_a_ovf", a_ovf, 1'b0);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        chk("ovf_a_dig", a_dig, 8'h00);
        chk("ovf_a_ovf", a_ovf, 1'b1);
        chk("ovf_s_dig", s_dig, 8'h99);
        chk("ovf_s_ovf", s_ovf, 1'b1);
        chk("ovf_c_dig", c_dig, 12'h100);
        chk("ovf_c_ovf", c_ovf, 1'b0);

        // Clear then decrement at zero.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_s_dig", s_dig, 8'h00);
        dec = 1'b1;
        tick();
        dec = 1'b0;
        chk("unf_a_dig", a_dig, 8'h99);
        chk("unf_a_unf", a_unf, 1'b1);
        chk("unf_s_dig", s_dig, 8'h00);
        chk("unf_s_unf", s_unf, 1'b1);
        chk("unf_c_dig", c_dig, 12'h999);
        chk("unf_c_unf", c_unf, 1'b1);
        tick();
        chk("unf_a_pulse", a_unf, 1'b0);

        // Borrow chain: 100 -> 099; 10 -> 09 on the 2-digit counter.
        ld = 1'b1; lv = 12'h100;
        tick();
        ld = 1'b0;
        dec = 1'b1;
        tick();
        dec = 1'b0;
        chk("brw_c_dig", c_dig, 12'h099);
        chk("brw_c_unf", c_unf, 1'b0);
        ld = 1'b1; lv = 12'h010;
        tick();
        ld = 1'b0;
        dec = 1'b1;
        tick();
        dec = 1'b0;
        chk("brw_a_dig", a_dig, 8'h09);

        // Both strobes together hold.
        ld = 1'b1; lv = 12'h042;
        tick();
        ld = 1'b0;
        inc = 1'b1; dec = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0;
        chk("both_a_dig", a_dig, 8'h42);
        chk("both_c_dig", c_dig, 12'h042);

        // Clear and load cancel a count at all-9s: no ovf.
        ld = 1'b1; lv = 12'h099;
        tick();
        ld = 1'b0;
        clr = 1'b1; inc = 1'b1;
        tick();
        clr = 1'b0; inc = 1'b0;
        chk("clrinc_a_dig", a_dig, 8'h00);
        chk("clrinc_a_ovf", a_ovf, 1'b0);
        ld = 1'b1; lv = 12'h099; inc = 1'b1;
        tick();
        ld = 1'b0; inc = 1'b0;
        chk("ldinc_a_dig", a_dig, 8'h99);
        chk("ldinc_a_ovf", a_ovf, 1'b0);

        // Load clamping of non-BCD nibbles.
        ld = 1'b1; lv = 12'h0A7;
        tick();
        ld = 1'b0;
        chk("clamp_a_dig", a_dig, 8'h97);
        ld = 1'b1; lv = 12'hFAB;
        tick();
        ld = 1'b0;
        chk("clamp_c_dig", c_dig, 12'h999);
        chk("clamp_c_max", c_max, 1'b1);

        // Reset mid-count with d_inc high, then resume.
        ld = 1'b1; lv = 12'h057;
        tick();
        ld = 1'b0;
        chk("mid_a_dig", a_dig, 8'h57);
        rst = 1'b1; inc = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dig", a_dig, 8'h00);
        chk("mid_rst_ovf", a_ovf, 1'b0);
        chk("mid_rst_zero", a_zero, 1'b1);
        tick();
        inc = 1'b0;
        chk("mid_resume", a_dig, 8'h01);
        chk("mid_a_win", a_win, 1'b0);
`endif

        // Win instance: 11 back-to-back increments.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            w_inc = 1'b1;
            tick();
            chk("w_inc_dig", w_dig, bcd(k));
            chk("w_inc_win", w_win, 1'b0);
        end
        w_inc = 1'b0;
        tick();
        chk("w_win_set", w_win, WIN_EN);
        w_inc = 1'b1;
        tick();
        w_inc = 1'b0;
        chk("w_frozen_dig", w_dig, WIN_EN ? 8'h11 : 8'h12);
        chk("w_frozen_ovf", w_ovf, 1'b0);
        chk("w_win_hold", w_win, WIN_EN);
        w_clr = 1'b1;
        tick();
        w_clr = 1'b0;
        chk("w_clr_dig", w_dig, 8'h00);
        chk("w_clr_win", w_win, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
